regfile_wp_arbiter: RTL and testbench
=====================================

// Module: regfile_wp_arbiter
// PURPOSE
//  Arbitrates the register file's single write port between two requesters.
//  Requester A is pipeline writeback: highest priority, never stalled, never dropped.
//  Requester B is a multicycle unit (div/LSU): buffered in a DEPTH-entry FIFO.
//  Also provides a pending-write scoreboard so decode can detect RAW hazards on
//  writes that are buffered but not yet committed to regfile.
//  Sits between WB stage / multicycle unit and regfile (we/wa/wd).
// PARAMETERS
//  XLEN          32  data width
//  AW            5   register address width
//  DEPTH         4   B-request FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  8   cycles FIFO head may wait before pipe_stall asserts (>=1)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous, active-low reset
//  wb_valid    in   1              A write request this cycle
//  wb_rd       in   AW             A dest register
//  wb_data     in   XLEN           A write data
//  mc_valid    in   1              B request valid
//  mc_ready    out  1              B request accepted when valid&ready at posedge
//  mc_rd       in   AW             B dest register
//  mc_data     in   XLEN           B write data
//  rf_we       out  1              regfile write enable
//  rf_wa       out  AW             regfile write address
//  rf_wd       out  XLEN           regfile write data
//  pipe_stall  out  1              request pipeline to insert WB bubble
//  chk_ra1     in   AW             hazard query address 1
//  chk_ra2     in   AW             hazard query address 2
//  chk_hit1    out  1              chk_ra1 has a pending buffered write
//  chk_hit2    out  1              chk_ra2 has a pending buffered write
//  pend_count  out  $clog2(DEPTH+1) valid FIFO entries
// BEHAVIOUR
//  Reset (async, while rst_n=0): FIFO empty, pointers 0, wait_cnt 0.
//   Outputs: rf_we=0 (gated by rst_n), mc_ready=1 after release, pipe_stall=0,
//   pend_count=0, chk_hit*=0.
//  Write port (combinational, same cycle; regfile commits at the closing edge):
//   - wb_valid && wb_rd!=0          -> rf_we=1, wa=wb_rd, wd=wb_data (A grant)
//   - else FIFO non-empty           -> rf_we=1, wa/wd = head; head dequeued at edge
//   - else                          -> rf_we=0, wa/wd=0
//   - A with wb_rd=0 counts as idle, so the slot goes to B.
//  B enqueue: mc_ready = (pend_count < DEPTH), derived from registered count only.
//   - A full FIFO stays not-ready even in a dequeue cycle.
//   - mc_rd=0 on handshake: accepted and discarded; not enqueued; no write.
//   - Earliest commit: the cycle after acceptance. No bypass.
//   - Strict FIFO order for B writes.
//  pend_count: +1 on enqueue, -1 on dequeue, unchanged on both or neither.
//  Starvation: wait_cnt +1 each cycle FIFO non-empty and head not granted.
//   - Clears to 0 on dequeue or when FIFO empty; saturates at STARVE_LIMIT.
//   - pipe_stall = (wait_cnt == STARVE_LIMIT); held until head dequeued.
//   - If A remains valid while stalled, A still wins (never dropped).
//  Scoreboard: chk_hitN=1 iff chk_raN!=0 and a valid FIFO entry (incl. head being
//   written this cycle) has rd==chk_raN. Incoming un-accepted mc_* is excluded.
//  Reset mid-operation: all buffered B writes are lost; rf_we drops immediately.
// TESTING
//  1 Reset: rst_n=0, wb_valid=1 rd=5 -> rf_we=0, pend_count=0, pipe_stall=0;
//    after release, mc_ready=1.
//  2 A path: wb_valid=1 rd=5 data=99 -> same cycle rf_we=1 wa=5 wd=99;
//    rd=0 -> rf_we=0.
//  3 B path: mc rd=10 data=12345 accepted -> next cycle rf_we=1 wa=10 wd=12345,
//    pend_count 1->0; regfile read rd=12345.
//  4 Contention: A valid every cycle, B rd=7 queued -> chk_ra1=7 gives chk_hit1=1;
//    after 8 waiting cycles pipe_stall=1; A drops -> B writes x7, stall clears next cycle.
//  5 Full: 4 B enqueues (rd=1..4) with A busy -> mc_ready=0, 5th held;
//    drain writes x1,x2,x3,x4 in order.
//  6 x0/mid-reset: mc rd=0 -> accepted, pend_count unchanged, no write;
//    rst_n pulse with 3 pending -> pend_count=0, no writes afterwards.

Source files
------------

// File: rtl/regfile_wp_arbiter.sv
// Register-file write-port arbiter: writeback (A) has absolute priority, multicycle
// results (B) are buffered in a small FIFO with a pending-write scoreboard and starvation stall.
module regfile_wp_arbiter #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    input  logic [AW-1:0]              wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [AW-1:0]              mc_rd,
    input  logic [XLEN-1:0]            mc_data,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_wa,
    output logic [XLEN-1:0]            rf_wd,
    output logic                       pipe_stall,
    input  logic [AW-1:0]              chk_ra1,
    input  logic [AW-1:0]              chk_ra2,
    output logic                       chk_hit1,
    output logic                       chk_hit2,
    output logic [$clog2(DEPTH+1)-1:0] pend_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(STARVE_LIMIT+1);

    logic [AW-1:0]   fifo_rd_r   [DEPTH];
    logic [XLEN-1:0] fifo_data_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [WW-1:0]   wait_cnt_r;

    logic a_grant_s;
    logic empty_s;
    logic deq_s;
    logic enq_s;

    // Arbitration and write-port mux; rd=0 requests are treated as idle, rf_we is gated by reset.
    always_comb begin
        a_grant_s = wb_valid && (wb_rd != {AW{1'b0}});
        empty_s   = (count_r == {CW{1'b0}});
        mc_ready  = (count_r < CW'(DEPTH));
        deq_s     = !a_grant_s && !empty_s;
        enq_s     = mc_valid && mc_ready && (mc_rd != {AW{1'b0}});
        if (!rst_n) begin
            rf_we = 1'b0;
            rf_wa = {AW{1'b0}};
            rf_wd = {XLEN{1'b0}};
        end else if (a_grant_s) begin
            rf_we = 1'b1;
            rf_wa = wb_rd;
            rf_wd = wb_data;
        end else if (!empty_s) begin
            rf_we = 1'b1;
            rf_wa = fifo_rd_r[rd_ptr_r];
            rf_wd = fifo_data_r[rd_ptr_r];
        end else begin
            rf_we = 1'b0;
            rf_wa = {AW{1'b0}};
            rf_wd = {XLEN{1'b0}};
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_r[i]   <= {AW{1'b0}};
                fifo_data_r[i] <= {XLEN{1'b0}};
            end
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                fifo_rd_r[wr_ptr_r]   <= mc_rd;
                fifo_data_r[wr_ptr_r] <= mc_data;
                wr_ptr_r              <= wr_ptr_r + PW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-FIFO starvation counter, saturating at the stall threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if (empty_s || deq_s) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if (wait_cnt_r != WW'(STARVE_LIMIT)) begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Pending-write scoreboard over the valid FIFO window, plus status outputs.
    always_comb begin
        chk_hit1 = 1'b0;
        chk_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_hit1 = chk_hit1 | ((CW'(i) < count_r) && (chk_ra1 != {AW{1'b0}}) &&
                                   (fifo_rd_r[rd_ptr_r + PW'(i)] == chk_ra1));
            chk_hit2 = chk_hit2 | ((CW'(i) < count_r) && (chk_ra2 != {AW{1'b0}}) &&
                                   (fifo_rd_r[rd_ptr_r + PW'(i)] == chk_ra2));
        end
        pipe_stall = (wait_cnt_r == WW'(STARVE_LIMIT));
        pend_count = count_r;
    end

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// Scoreboard bench for regfile_wp_arbiter: a driver pushes expectations from a queue-based
// reference model, a negedge monitor pops and compares them against the DUT.
module tb_regfile_wp_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            mc_valid = 1'b0;
    logic            mc_ready;
    logic [AW-1:0]   mc_rd = '0;
    logic [XLEN-1:0] mc_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            pipe_stall;
    logic [AW-1:0]   chk_ra1 = '0;
    logic [AW-1:0]   chk_ra2 = '0;
    logic            chk_hit1;
    logic            chk_hit2;
    logic [2:0]      pend_count;

    regfile_wp_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pipe_stall(pipe_stall),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } wr_t;
    typedef struct { logic ready; logic stall; int pend; logic hit1; logic hit2; } st_t;

    wr_t model_q[$];
    wr_t exp_wr_q[$];
    st_t exp_st_q[$];
    int  model_wait = 0;
    int  checks = 0;
    int  failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // One clock cycle of stimulus; expectations come from the reference model, then it advances.
    task automatic cycle(input bit wv, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd,
                         input bit mv, input logic [AW-1:0] mr, input logic [XLEN-1:0] md,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, output bit acc);
        st_t st;
        wr_t w;
        bit  a;
        int  sz;
        @(posedge clk);
        #1;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        mc_valid = mv; mc_rd = mr; mc_data = md;
        chk_ra1 = r1; chk_ra2 = r2;
        a  = wv && (wr != 0);
        sz = model_q.size();
        st.ready = (sz < DEPTH);
        st.stall = (model_wait == LIM);
        st.pend  = sz;
        st.hit1  = 1'b0;
        st.hit2  = 1'b0;
        foreach (model_q[i]) begin
            if (r1 != 0 && model_q[i].rd == r1) st.hit1 = 1'b1;
            if (r2 != 0 && model_q[i].rd == r2) st.hit2 = 1'b1;
        end
        exp_st_q.push_back(st);
        if (a) begin
            w.rd = wr; w.data = wd;
            exp_wr_q.push_back(w);
        end else if (sz > 0) begin
            exp_wr_q.push_back(model_q[0]);
        end
        if (!a && sz > 0) begin
            void'(model_q.pop_front());
            model_wait = 0;
        end else if (sz > 0) begin
            model_wait = (model_wait < LIM) ? model_wait + 1 : LIM;
        end else begin
            model_wait = 0;
        end
        acc = mv && st.ready;
        if (acc && mr != 0) begin
            w.rd = mr; w.data = md;
            model_q.push_back(w);
        end
    endtask

    // Monitor: compares status every cycle and pops an expected write whenever rf_we is seen.
    initial begin
        st_t st;
        wr_t w;
        forever begin
            @(negedge clk);
            if (exp_st_q.size() > 0) begin
                st = exp_st_q.pop_front();
                chk("mc_ready", mc_ready, st.ready);
                chk("pipe_stall", pipe_stall, st.stall);
                chk("pend_count", pend_count, st.pend);
                chk("chk_hit1", chk_hit1, st.hit1);
                chk("chk_hit2", chk_hit2, st.hit2);
            end
            if (rf_we === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual wa=%0d wd=%0d required no write", rf_wa, rf_wd);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("rf_wa", rf_wa, w.rd);
                    chk("rf_wd", rf_wd, w.data);
                end
            end
        end
    end

    initial begin
        bit acc;
        bit mv;
        logic [AW-1:0] mr;
        logic [XLEN-1:0] md;
        int pa;

        // Reset with A requesting: write port must stay quiet.
        rst_n = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd1;
        #2;
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_pend", pend_count, 0);
        chk("reset_stall", pipe_stall, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        #1;
        chk("release_mc_ready", mc_ready, 1'b1);

        // A path, then A with rd=0.
        cycle(1, 5, 99, 0, 0, 0, 0, 0, acc);
        cycle(1, 0, 123, 0, 0, 0, 0, 0, acc);

        // B path with one-cycle latency.
        cycle(0, 0, 0, 1, 10, 12345, 10, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 10, 10, acc);
        cycle(0, 0, 0, 0, 0, 0, 10, 0, acc);

        // Contention: B rd=7 starves behind continuous A, then A drops.
        cycle(1, 3, 333, 1, 7, 777, 7, 0, acc);
        for (int i = 0; i < 10; i++)
            cycle(1, 5'(1 + (i % 30)), $urandom, 0, 0, 0, 7, 3, acc);
        cycle(0, 0, 0, 0, 0, 0, 7, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 7, 0, acc);

        // Fill the FIFO behind A, hold the 5th request, then drain in order.
        for (int i = 1; i <= 4; i++)
            cycle(1, 5'd20, 32'(i), 1, 5'(i), 32'(i * 100), 5'(i), 0, acc);
        acc = 0;
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd21, 32'(i), 1, 5'd5, 32'd500, 5'd5, 5'd1, acc);
        for (int i = 0; i < 8; i++) begin
            mv = !acc;
            cycle(0, 0, 0, mv, 5'd5, 32'd500, 5'd3, 5'd5, acc);
            if (!mv) acc = 1;
        end

        // Request to x0 is swallowed.
        cycle(0, 0, 0, 1, 0, 32'hdead, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Three pending writes lost on a mid-operation reset.
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd9, 32'(i), 1, 5'(11 + i), 32'(i), 5'd11, 0, acc);
        @(posedge clk); #1;
        rst_n = 1'b0; mc_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; chk_ra1 = 5'd12;
        #1;
        chk("midreset_rf_we", rf_we, 1'b0);
        chk("midreset_pend", pend_count, 0);
        chk("midreset_hit", chk_hit1, 1'b0);
        model_q.delete();
        model_wait = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 0, 0, 0, 5'd12, 5'd13, acc);

        // Randomized traffic with varying A pressure; B requests held until accepted.
        mv = 0; mr = '0; md = '0; acc = 1;
        for (int blk = 0; blk < 8; blk++) begin
            pa = (blk % 4) * 30 + 5;
            for (int i = 0; i < 60; i++) begin
                if (acc || !mv) begin
                    mv = ($urandom_range(99) < 50);
                    mr = 5'($urandom_range(7));
                    md = $urandom;
                end
                cycle($urandom_range(99) < pa, 5'($urandom_range(31)), $urandom,
                      mv, mr, md, 5'($urandom_range(7)), 5'($urandom_range(7)), acc);
            end
        end
        for (int i = 0; i < 12; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        @(negedge clk); #1;
        chk("writes_outstanding", exp_wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
